// File: rtl/mysystem_led_seq_pkg.sv
`default_nettype none
// ============================================================================
// mysystem_led_seq_pkg : shared encodings for the LED pattern sequencer
// Revision: 1.0
// ============================================================================
package mysystem_led_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_CHECK = 3'd4
  } state_t;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PERIOD  = 2'd1;
  localparam logic [1:0] REG_PATTERN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam logic [1:0] MODE_ROTL  = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_ROTR  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mysystem_led_seq_tick.sv
`default_nettype none
// ============================================================================
// mysystem_led_seq_tick : period counter, terminal count at max(limit,1)-1
// Revision: 1.0
// ============================================================================
module mysystem_led_seq_tick #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [PERIOD_W-1:0] i_limit,
  output logic                o_tc
);

  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] w_last;

  // A zero limit behaves like a limit of one.
  assign w_last = (i_limit == '0) ? '0 : i_limit - 1'b1;
  assign o_tc   = (r_cnt == w_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == w_last) r_cnt <= '0;
      else                 r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mysystem_led_sequencer.sv
`default_nettype none
// ============================================================================
// mysystem_led_sequencer : steps an LED pattern, writes it to the PIO, verifies readback
// Revision: 1.0
// ============================================================================
module mysystem_led_sequencer
  import mysystem_led_seq_pkg::*;
#(
  parameter int LED_W          = 4,
  parameter int PERIOD_W       = 32,
  parameter int PERIOD_DEFAULT = 50_000_000,
  parameter int STEP_W         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        busy,
  output logic        err
);

  localparam logic [PERIOD_W-1:0] C_PERIOD_RST = PERIOD_W'(PERIOD_DEFAULT);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_ctrl;
  logic [PERIOD_W-1:0] r_period;
  logic [LED_W-1:0]    r_pattern, w_pattern_nxt, r_rdback;
  logic [STEP_W-1:0]   r_step;
  logic                r_err;
  logic                w_wr, w_enable, w_tick_clr, w_tick_en, w_tick_tc;
  logic [1:0]          w_mode;
  logic                w_unused_rd;

  assign w_wr        = s_chipselect & ~s_write_n;
  assign w_enable    = r_ctrl[0];
  assign w_mode      = r_ctrl[2:1];
  assign w_unused_rd = ^m_readdata[31:LED_W];

  mysystem_led_seq_tick #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_tick_clr),
    .i_en    (w_tick_en),
    .i_limit (r_period),
    .o_tc    (w_tick_tc)
  );

  always_comb begin
    w_pattern_nxt = r_pattern;
    case (w_mode)
      MODE_ROTL:  w_pattern_nxt = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
      MODE_BLINK: w_pattern_nxt = ~r_pattern;
      MODE_COUNT: w_pattern_nxt = r_pattern + 1'b1;
      MODE_ROTR:  w_pattern_nxt = {r_pattern[0], r_pattern[LED_W-1:1]};
      default:    w_pattern_nxt = r_pattern;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_tick_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_clr = 1'b1;
        if (w_enable) w_state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (!w_enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tick_en = 1'b1;
          if (w_tick_tc) w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: w_state_nxt = ST_READ;
      ST_READ:  w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = w_enable ? ST_COUNT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_period  <= C_PERIOD_RST;
      r_pattern <= '1;
      r_rdback  <= '0;
      r_step    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr && s_address == REG_CTRL)   r_ctrl   <= s_writedata[2:0];
      if (w_wr && s_address == REG_PERIOD) r_period <= s_writedata[PERIOD_W-1:0];
      // A CPU pattern write beats the automatic step in the same cycle.
      if (w_wr && s_address == REG_PATTERN)
        r_pattern <= s_writedata[LED_W-1:0];
      else if (r_state == ST_COUNT && w_state_nxt == ST_WRITE)
        r_pattern <= w_pattern_nxt;
      if (r_state == ST_READ) r_rdback <= m_readdata[LED_W-1:0];
      if (w_wr && s_address == REG_STATUS) begin
        r_step <= '0;
        r_err  <= 1'b0;
      end else if (r_state == ST_CHECK) begin
        r_step <= r_step + 1'b1;
        if (r_rdback != r_pattern) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    s_readdata = '0;
    case (s_address)
      REG_CTRL:    s_readdata[2:0]          = r_ctrl;
      REG_PERIOD:  s_readdata[PERIOD_W-1:0] = r_period;
      REG_PATTERN: s_readdata[LED_W-1:0]    = r_pattern;
      REG_STATUS:  s_readdata[STEP_W:0]     = {r_err, r_step};
      default:     s_readdata               = '0;
    endcase
  end

  // Strobes decode straight from the state register so reset drops them at once.
  assign m_address    = 2'b00;
  assign m_chipselect = (r_state == ST_WRITE) || (r_state == ST_READ);
  assign m_write_n    = (r_state != ST_WRITE);
  assign m_writedata  = (r_state == ST_WRITE) ? {{(32-LED_W){1'b0}}, r_pattern} : '0;
  assign busy         = (r_state != ST_IDLE);
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mysystem_led_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mysystem_led_sequencer : directed stimulus with a PIO-write scoreboard
// Revision: 1.0
// ============================================================================
module tb_mysystem_led_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  s_address = 2'd0;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = 32'd0;
  logic [31:0] s_readdata;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [31:0] m_writedata, m_readdata;
  logic        busy, err;
  logic [31:0] pio_reg;
  logic        corrupt = 1'b0;
  int          cyc = 0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  mysystem_led_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PIO slave model; corrupt forces a bad readback.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) pio_reg <= 32'hF;
    else if (m_chipselect && !m_write_n) pio_reg <= m_writedata;
  always_comb m_readdata = corrupt ? 32'h0 : pio_reg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int ew);
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
    ew = cyc;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    s_address = a; s_chipselect = 1'b1; s_write_n = 1'b1;
    #1;
    chk(nm, s_readdata, exp);
    s_chipselect = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input int c);
    exp_t e;
    e.d = d; e.c = c;
    q.push_back(e);
  endtask

  initial begin
    int t, e;
    fork
      forever begin
        @(negedge clk);
        if (reset_n && m_chipselect && !m_write_n) begin
          if (q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_pio_write: got %h expected none (cycle %0d)", m_writedata, cyc);
          end else begin
            exp_t x;
            x = q.pop_front();
            chk("pio_data", m_writedata, x.d);
            chk("pio_cycle", 32'(cyc), 32'(x.c));
          end
        end
      end
    join_none

    // 1: reset state and register defaults
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cs", 32'(m_chipselect), 32'd0);
    chk("rst_wn", 32'(m_write_n), 32'd1);
    chk("rst_wdata", m_writedata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd1, 32'd50_000_000, "rst_period");
    rd(2'd3, 32'd0, "rst_status");
    rd(2'd2, 32'hF, "rst_pattern");
    rd(2'd0, 32'd0, "rst_ctrl");

    // 2 + 5a: rotate left, enable dropped as the 4th WRITE begins
    wr(2'd1, 32'd4, t);
    wr(2'd2, 32'd1, t);
    wr(2'd0, 32'd1, e);
    push(32'h2, e + 5); push(32'h4, e + 12); push(32'h8, e + 19); push(32'h1, e + 26);
    wait_cyc(e + 25);
    wr(2'd0, 32'd0, t);
    wait_cyc(e + 28);
    chk("busy_in_check", 32'(busy), 32'd1);
    wait_cyc(e + 29);
    chk("idle_after_check", 32'(busy), 32'd0);
    rd(2'd3, 32'd4, "status_rotl");

    // 3: blink, then enable dropped in COUNT
    wr(2'd2, 32'd5, t);
    wr(2'd0, 32'd3, e);
    push(32'hA, e + 5); push(32'h5, e + 12); push(32'hA, e + 19);
    wait_cyc(e + 23);
    wr(2'd0, 32'd0, t);
    chk("busy_count_disable", 32'(busy), 32'd1);
    wait_cyc(e + 25);
    chk("idle_count_disable", 32'(busy), 32'd0);
    rd(2'd3, 32'd7, "status_blink");

    // 3: count mode with wrap
    wr(2'd2, 32'hE, t);
    wr(2'd0, 32'd5, e);
    push(32'hF, e + 5); push(32'h0, e + 12);
    wait_cyc(e + 14);
    wr(2'd0, 32'd0, t);
    wait_cyc(e + 17);
    chk("idle_count_mode", 32'(busy), 32'd0);
    rd(2'd3, 32'd9, "status_count");

    // 4: corrupted readback sets sticky err; disable lands on terminal count
    wr(2'd2, 32'd1, t);
    wr(2'd0, 32'd1, e);
    push(32'h2, e + 5); push(32'h4, e + 12);
    wait_cyc(e + 6);
    corrupt = 1'b1;
    wait_cyc(e + 7);
    corrupt = 1'b0;
    wait_cyc(e + 8);
    chk("err_set", 32'(err), 32'd1);
    wait_cyc(e + 15);
    chk("err_sticky", 32'(err), 32'd1);
    wait_cyc(e + 17);
    wr(2'd0, 32'd0, t);
    wait_cyc(e + 20);
    rd(2'd3, 32'h0001_000B, "status_err");
    wr(2'd3, 32'd0, t);
    chk("err_cleared", 32'(err), 32'd0);
    rd(2'd3, 32'd0, "status_cleared");

    // 6a: asynchronous reset during READ
    wr(2'd0, 32'd1, e);
    push(32'h8, e + 5);
    wait_cyc(e + 6);
    chk("cs_in_read", 32'(m_chipselect), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("cs_async_rst", 32'(m_chipselect), 32'd0);
    chk("busy_async_rst", 32'(busy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd1, 32'd50_000_000, "period_after_rst");
    rd(2'd0, 32'd0, "ctrl_after_rst");

    // 6b: PERIOD=0 behaves as 1
    wr(2'd1, 32'd0, t);
    wr(2'd2, 32'd1, t);
    wr(2'd0, 32'd1, e);
    push(32'h2, e + 2); push(32'h4, e + 6); push(32'h8, e + 10);
    wait_cyc(e + 9);
    wr(2'd0, 32'd0, t);
    wait_cyc(e + 14);
    chk("idle_period0", 32'(busy), 32'd0);
    rd(2'd3, 32'd3, "status_period0");

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
